// File: rtl/jtbubl_pkg.sv
// Shared definitions for the jtbubl sound mailbox.
//   - Register select codes seen on main_addr / snd_addr.
//   - NMI handshake state encoding.
package jtbubl_pkg;

  localparam logic [1:0] CMD    = 2'd0;
  localparam logic [1:0] NMIEN  = 2'd1;
  localparam logic [1:0] NMIDIS = 2'd2;
  localparam logic [1:0] SRST   = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StRelease = 2'd2
  } nmi_st_e;

endpackage

// File: rtl/jtbubl_sndcomm_edge.sv
// Chip-select rising-edge detector.
//   rst   in  asynchronous reset, active high
//   clk24 in  system clock
//   cs    in  bus select level
//   stb   out high for the first cycle cs is seen high
module jtbubl_sndcomm_edge (
  input  logic rst,
  input  logic clk24,
  input  logic cs,
  output logic stb
);

  logic cs_q;

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) cs_q <= 1'b0;
    else     cs_q <= cs;
  end

  assign stb = cs & ~cs_q;

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Mailbox between the main Z80 and the sound Z80.
//   Main side : main_cs/main_wrn/main_addr/main_dout in, main_din out (combinational).
//               addr 0 write = command latch, addr 3 write = sound CPU reset bit.
//   Sound side: snd_cs/snd_wrn/snd_addr/snd_dout in, snd_din out (combinational).
//               addr 0 read = command (NMI acknowledge), addr 1/2 write = NMI enable/disable.
//   snd_rst   : registered sound CPU reset, high out of reset.
//   snd_nmi_n : registered NMI, one pulse per command.
// Optional feature: define SNDCOMM_REPLY_EN to build the sound-to-main reply byte.
module jtbubl_sndcomm
  import jtbubl_pkg::*;
#(
  parameter int unsigned NMI_MIN = 32,
  parameter int unsigned NMI_TO  = 4095
) (
  input  logic       rst,
  input  logic       clk24,
  input  logic       main_cs,
  input  logic       main_wrn,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  output logic       snd_rst,
  input  logic       snd_cs,
  input  logic       snd_wrn,
  input  logic [1:0] snd_addr,
  input  logic [7:0] snd_dout,
  output logic [7:0] snd_din,
  output logic       snd_nmi_n
);

  localparam int unsigned CW = $clog2(NMI_TO + 1);
  localparam logic [CW-1:0] MIN_C   = CW'(NMI_MIN);
  localparam logic [CW-1:0] TO_C    = CW'(NMI_TO);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic main_stb, snd_stb;

  jtbubl_sndcomm_edge u_main_edge (
    .rst   (rst),
    .clk24 (clk24),
    .cs    (main_cs),
    .stb   (main_stb)
  );

  jtbubl_sndcomm_edge u_snd_edge (
    .rst   (rst),
    .clk24 (clk24),
    .cs    (snd_cs),
    .stb   (snd_stb)
  );

  logic main_wr, main_rd, snd_wr, snd_rd;
  logic main_cmd_wr, main_srst_wr;
  logic snd_ack, snd_nmien_wr, snd_nmidis_wr;

  assign main_wr = main_stb & ~main_wrn;
  assign main_rd = main_stb &  main_wrn;
  assign snd_wr  = snd_stb  & ~snd_wrn;
  assign snd_rd  = snd_stb  &  snd_wrn;

  assign main_cmd_wr   = main_wr && (main_addr == CMD);
  assign main_srst_wr  = main_wr && (main_addr == SRST);
  assign snd_ack       = snd_rd  && (snd_addr == CMD);
  assign snd_nmien_wr  = snd_wr  && (snd_addr == NMIEN);
  assign snd_nmidis_wr = snd_wr  && (snd_addr == NMIDIS);

  // Main-side state: only the global reset touches it.
  logic [7:0] cmd_latch_q;
  logic       cmd_pend_q;
  logic       snd_rst_q;

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      cmd_latch_q <= 8'h00;
      cmd_pend_q  <= 1'b0;
      snd_rst_q   <= 1'b1;
    end else begin
      if (main_cmd_wr)  cmd_latch_q <= main_dout;
      // A new command wins over a simultaneous acknowledge.
      if (main_cmd_wr)  cmd_pend_q <= 1'b1;
      else if (snd_ack) cmd_pend_q <= 1'b0;
      if (main_srst_wr) snd_rst_q <= main_dout[0];
    end
  end

  assign snd_rst = snd_rst_q;

  // Reply path.
  logic rep_pend;
`ifdef SNDCOMM_REPLY_EN
  logic [7:0] reply_q;
  logic       rep_pend_q;
  logic       main_rep_rd, snd_rep_wr;

  assign main_rep_rd = main_rd && (main_addr == CMD);
  assign snd_rep_wr  = snd_wr  && (snd_addr == CMD);

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      reply_q    <= 8'h00;
      rep_pend_q <= 1'b0;
    end else if (snd_rst_q) begin
      reply_q    <= 8'h00;
      rep_pend_q <= 1'b0;
    end else begin
      if (snd_rep_wr)       reply_q <= snd_dout;
      if (snd_rep_wr)       rep_pend_q <= 1'b1;
      else if (main_rep_rd) rep_pend_q <= 1'b0;
    end
  end

  assign rep_pend = rep_pend_q;
`else
  logic unused_reply;
  assign unused_reply = ^{snd_dout, main_rd};
  assign rep_pend     = 1'b0;
`endif

  // NMI handshake.
  nmi_st_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d, ack_seen;
  logic          new_cmd_q, new_cmd_d;
  logic          nmi_n_q, nmi_n_d;
  logic          nmi_en_q;

  // cnt_q holds the number of ASSERT cycles so far, including the current one,
  // so the low width equals the count value at which the FSM leaves ASSERT.
  // new_cmd_q marks a command written after this pulse was acknowledged (or
  // during RELEASE): it keeps cmd_pend high but still deserves its own NMI.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    ack_d     = 1'b0;
    new_cmd_d = 1'b0;
    ack_seen  = ack_q | snd_ack;
    unique case (state_q)
      StIdle: begin
        if (cmd_pend_q && nmi_en_q) begin
          state_d = StAssert;
          cnt_d   = CW'(1);
        end
      end
      StAssert: begin
        ack_d     = ack_seen;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        new_cmd_d = new_cmd_q | (main_cmd_wr & ack_seen);
        if ((ack_seen && cnt_q >= MIN_C) || cnt_q == TO_C) state_d = StRelease;
      end
      StRelease: begin
        new_cmd_d = new_cmd_q | main_cmd_wr;
        if (!cmd_pend_q || new_cmd_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    nmi_n_d = (state_d != StAssert);
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      new_cmd_q <= 1'b0;
      nmi_n_q   <= 1'b1;
      nmi_en_q  <= 1'b0;
    end else if (snd_rst_q) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      new_cmd_q <= 1'b0;
      nmi_n_q   <= 1'b1;
      nmi_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      new_cmd_q <= new_cmd_d;
      nmi_n_q   <= nmi_n_d;
      if (snd_nmien_wr)       nmi_en_q <= 1'b1;
      else if (snd_nmidis_wr) nmi_en_q <= 1'b0;
    end
  end

  assign snd_nmi_n = nmi_n_q;

  // Read multiplexers.
  always_comb begin
    main_din = 8'hFF;
    case (main_addr)
`ifdef SNDCOMM_REPLY_EN
      CMD:     main_din = reply_q;
`endif
      NMIEN:   main_din = {6'b0, cmd_pend_q, rep_pend};
      default: main_din = 8'hFF;
    endcase
  end

  always_comb begin
    snd_din = 8'hFF;
    case (snd_addr)
      CMD:     snd_din = cmd_latch_q;
      NMIEN:   snd_din = {nmi_en_q, 5'b0, cmd_pend_q, rep_pend};
      default: snd_din = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Self-checking bench for jtbubl_sndcomm: a table of register accesses with
// expected read data and reset-line state, then hand-written NMI sequences.
module tb_jtbubl_sndcomm;

`ifdef SNDCOMM_REPLY_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  localparam int K_MWR = 0;
  localparam int K_MRD = 1;
  localparam int K_SWR = 2;
  localparam int K_SRD = 3;
  localparam int NV    = 33;

  typedef struct {
    int         kind;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_din;
    logic       chk_din;
    logic       exp_nmi_n;
    logic       exp_srst;
  } vec_t;

  logic       rst, clk24;
  logic       main_cs, main_wrn;
  logic [1:0] main_addr;
  logic [7:0] main_dout, main_din;
  logic       snd_rst;
  logic       snd_cs, snd_wrn;
  logic [1:0] snd_addr;
  logic [7:0] snd_dout, snd_din;
  logic       snd_nmi_n;

  int checks = 0;
  int errors = 0;

  vec_t vecs [NV];

  jtbubl_sndcomm dut (
    .rst       (rst),
    .clk24     (clk24),
    .main_cs   (main_cs),
    .main_wrn  (main_wrn),
    .main_addr (main_addr),
    .main_dout (main_dout),
    .main_din  (main_din),
    .snd_rst   (snd_rst),
    .snd_cs    (snd_cs),
    .snd_wrn   (snd_wrn),
    .snd_addr  (snd_addr),
    .snd_dout  (snd_dout),
    .snd_din   (snd_din),
    .snd_nmi_n (snd_nmi_n)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input logic [1:0] a, input logic [7:0] d,
                              input logic [7:0] e, input logic c, input logic s);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp_din = e; v.chk_din = c;
    v.exp_nmi_n = 1'b1; v.exp_srst = s;
    return v;
  endfunction

  // Each access holds cs for one cycle and returns just after the strobe edge.
  task automatic main_acc(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    @(posedge clk24); #1;
    main_cs = 1'b1; main_wrn = ~wr; main_addr = a; main_dout = d;
    #3 q = main_din;
    @(posedge clk24); #1;
    main_cs = 1'b0; main_wrn = 1'b1;
  endtask

  task automatic snd_acc(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    @(posedge clk24); #1;
    snd_cs = 1'b1; snd_wrn = ~wr; snd_addr = a; snd_dout = d;
    #3 q = snd_din;
    @(posedge clk24); #1;
    snd_cs = 1'b0; snd_wrn = 1'b1;
  endtask

  // Main command write and sound latch read in the same cycle.
  task automatic both_acc(input logic [7:0] d, output logic [7:0] q);
    @(posedge clk24); #1;
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd0; main_dout = d;
    snd_cs  = 1'b1; snd_wrn  = 1'b1; snd_addr  = 2'd0;
    #3 q = snd_din;
    @(posedge clk24); #1;
    main_cs = 1'b0; main_wrn = 1'b1;
    snd_cs  = 1'b0; snd_wrn  = 1'b1;
  endtask

  // Poll snd_nmi_n once per cycle until it equals lvl or the budget runs out.
  task automatic wait_nmi(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= bound; i++) begin
      if (snd_nmi_n === lvl) begin
        ok = 1'b1;
        break;
      end
      if (i < bound) begin
        @(posedge clk24); #1;
      end
    end
  endtask

  logic [7:0] q;
  bit         ok;
  longint     t0, t1;

  initial begin
    // Register-level table; starts with snd_rst high out of reset.
    vecs[0]  = mk(K_MRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    vecs[1]  = mk(K_MRD, 2'd2, 8'h00, 8'hFF, 1'b1, 1'b1);
    vecs[2]  = mk(K_MRD, 2'd3, 8'h00, 8'hFF, 1'b1, 1'b1);
    vecs[3]  = mk(K_SRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    vecs[4]  = mk(K_MWR, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[5]  = mk(K_MWR, 2'd1, 8'hFF, 8'h00, 1'b0, 1'b0);
    vecs[6]  = mk(K_MWR, 2'd2, 8'hFF, 8'h00, 1'b0, 1'b0);
    vecs[7]  = mk(K_MRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[8]  = mk(K_MWR, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mk(K_MRD, 2'd1, 8'h00, 8'h02, 1'b1, 1'b0);
    vecs[10] = mk(K_SRD, 2'd1, 8'h00, 8'h02, 1'b1, 1'b0);
    vecs[11] = mk(K_SRD, 2'd2, 8'h00, 8'hFF, 1'b1, 1'b0);
    vecs[12] = mk(K_SRD, 2'd0, 8'h00, 8'h11, 1'b1, 1'b0);
    vecs[13] = mk(K_MRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[14] = mk(K_SWR, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0);
    vecs[15] = mk(K_MRD, 2'd1, 8'h00, REP ? 8'h01 : 8'h00, 1'b1, 1'b0);
    vecs[16] = mk(K_SRD, 2'd1, 8'h00, REP ? 8'h01 : 8'h00, 1'b1, 1'b0);
    vecs[17] = mk(K_MRD, 2'd0, 8'h00, REP ? 8'hA5 : 8'hFF, 1'b1, 1'b0);
    vecs[18] = mk(K_MRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[19] = mk(K_SWR, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[20] = mk(K_SRD, 2'd1, 8'h00, 8'h80, 1'b1, 1'b0);
    vecs[21] = mk(K_SWR, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[22] = mk(K_SRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[23] = mk(K_SWR, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[24] = mk(K_SWR, 2'd0, 8'h3C, 8'h00, 1'b0, 1'b0);
    vecs[25] = mk(K_MWR, 2'd3, 8'h01, 8'h00, 1'b0, 1'b1);
    vecs[26] = mk(K_SRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
    vecs[27] = mk(K_MRD, 2'd0, 8'h00, REP ? 8'h00 : 8'hFF, 1'b1, 1'b1);
    vecs[28] = mk(K_MWR, 2'd0, 8'h33, 8'h00, 1'b0, 1'b1);
    vecs[29] = mk(K_MWR, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[30] = mk(K_SRD, 2'd1, 8'h00, 8'h02, 1'b1, 1'b0);
    vecs[31] = mk(K_SRD, 2'd0, 8'h00, 8'h33, 1'b1, 1'b0);
    vecs[32] = mk(K_MRD, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);

    rst = 1'b1;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = 2'd0; main_dout = 8'h00;
    snd_cs  = 1'b0; snd_wrn  = 1'b1; snd_addr  = 2'd0; snd_dout  = 8'h00;
    repeat (3) @(posedge clk24);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      case (vecs[i].kind)
        K_MWR:   main_acc(1'b1, vecs[i].addr, vecs[i].data, q);
        K_MRD:   main_acc(1'b0, vecs[i].addr, vecs[i].data, q);
        K_SWR:   snd_acc(1'b1, vecs[i].addr, vecs[i].data, q);
        default: snd_acc(1'b0, vecs[i].addr, vecs[i].data, q);
      endcase
      if (vecs[i].chk_din) chk($sformatf("vec%0d din", i), {8'h0, q}, {8'h0, vecs[i].exp_din});
      chk($sformatf("vec%0d nmi_n", i), {15'h0, snd_nmi_n}, {15'h0, vecs[i].exp_nmi_n});
      chk($sformatf("vec%0d snd_rst", i), {15'h0, snd_rst}, {15'h0, vecs[i].exp_srst});
    end

    // Enabled NMI: low two cycles after the write, early ack, minimum width.
    snd_acc(1'b1, 2'd1, 8'h00, q);
    main_acc(1'b1, 2'd0, 8'h5A, q);
    chk("nmi high at N+1", {15'h0, snd_nmi_n}, 16'h1);
    @(posedge clk24); #1;
    chk("nmi low at N+2", {15'h0, snd_nmi_n}, 16'h0);
    t0 = $time;
    snd_acc(1'b0, 2'd0, 8'h00, q);
    chk("ack read 5A", {8'h0, q}, 16'h005A);
    wait_nmi(1'b1, 100, ok);
    t1 = $time;
    chk("min pulse ends", {15'h0, ok}, 16'h1);
    chk("min pulse width", 16'((t1 - t0) / 10), 16'd32);
    main_acc(1'b0, 2'd1, 8'h00, q);
    chk("status after ack", {8'h0, q}, 16'h0000);

    // Disabling NMI mid-pulse does not shorten it.
    main_acc(1'b1, 2'd0, 8'h55, q);
    @(posedge clk24); #1;
    chk("nmi low 55", {15'h0, snd_nmi_n}, 16'h0);
    t0 = $time;
    snd_acc(1'b1, 2'd2, 8'h00, q);
    snd_acc(1'b0, 2'd0, 8'h00, q);
    chk("ack read 55", {8'h0, q}, 16'h0055);
    wait_nmi(1'b1, 100, ok);
    t1 = $time;
    chk("dis pulse width", 16'((t1 - t0) / 10), 16'd32);

    // Disabled: no NMI until enabled, then within two cycles.
    main_acc(1'b1, 2'd0, 8'h11, q);
    wait_nmi(1'b0, 8, ok);
    chk("no nmi when disabled", {15'h0, ok}, 16'h0);
    snd_acc(1'b1, 2'd1, 8'h00, q);
    wait_nmi(1'b0, 2, ok);
    chk("nmi after enable", {15'h0, ok}, 16'h1);

    // New command coinciding with the acknowledge gets its own NMI.
    repeat (40) @(posedge clk24);
    #1 chk("nmi held without ack", {15'h0, snd_nmi_n}, 16'h0);
    both_acc(8'h22, q);
    chk("simul read 11", {8'h0, q}, 16'h0011);
    chk("simul release A+1", {15'h0, snd_nmi_n}, 16'h1);
    main_acc(1'b0, 2'd1, 8'h00, q);
    chk("simul cmd_pend kept", {8'h0, q}, 16'h0002);
    wait_nmi(1'b0, 10, ok);
    chk("second nmi", {15'h0, ok}, 16'h1);
    snd_acc(1'b0, 2'd0, 8'h00, q);
    chk("simul latch 22", {8'h0, q}, 16'h0022);
    wait_nmi(1'b1, 100, ok);
    chk("second nmi ends", {15'h0, ok}, 16'h1);

    // Timeout without acknowledge, then no retrigger while cmd_pend stays set.
    main_acc(1'b1, 2'd0, 8'h44, q);
    @(posedge clk24); #1;
    chk("to nmi low", {15'h0, snd_nmi_n}, 16'h0);
    t0 = $time;
    wait_nmi(1'b1, 5000, ok);
    t1 = $time;
    chk("timeout ends", {15'h0, ok}, 16'h1);
    chk("timeout width", 16'((t1 - t0) / 10), 16'd4095);
    wait_nmi(1'b0, 50, ok);
    chk("no retrigger", {15'h0, ok}, 16'h0);
    main_acc(1'b0, 2'd1, 8'h00, q);
    chk("to cmd_pend", {8'h0, q}, 16'h0002);
    snd_acc(1'b0, 2'd0, 8'h00, q);
    chk("to latch 44", {8'h0, q}, 16'h0044);
    wait_nmi(1'b0, 20, ok);
    chk("idle after late read", {15'h0, ok}, 16'h0);
    main_acc(1'b0, 2'd1, 8'h00, q);
    chk("final status", {8'h0, q}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
